// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the first-word-fall-through FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 96;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;

  // Ceiling log2; usable in constant expressions for pointer widths.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = FIFO_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
  parameter int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO: head entry is always on dout, rd pops it.
module fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = FIFO_WIDTH_DEFAULT,
  parameter int unsigned DEPTH      = FIFO_DEPTH_DEFAULT,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  parameter bit          SIM_CHECKS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             almost_empty
);

  localparam int unsigned AW = clog2(DEPTH);

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   HALF_CNT = (AW + 1)'(DEPTH / 2);
  localparam logic [AW:0]   AF_CNT   = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_CNT   = (AW + 1)'(AE_LEVEL);
  localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] head;

  // Flags decode registered count only; never the current wr/rd.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign half_full    = (count_q >= HALF_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

  // A pop in the same cycle frees the slot a write into a full FIFO needs.
  assign wr_en = wr && (!full || rd);
  assign rd_en = rd && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ONE_PTR;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + ONE_PTR;
    end
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en && reset),
    .waddr(wr_ptr_q),
    .wdata(din),
    .raddr(rd_ptr_q),
    .rdata(head)
  );

  assign dout = empty ? '0 : head;

  wr_while_full_a : assert property (@(posedge clk) disable iff (!SIM_CHECKS || !reset)
    !(wr && full && !rd))
    else $error("fifo: write while full without rd, word dropped");

  rd_while_empty_a : assert property (@(posedge clk) disable iff (!SIM_CHECKS || !reset)
    !(rd && empty))
    else $error("fifo: rd while empty ignored");

endmodule

// File: tb/tb_fifo.sv
// Randomised and directed bench for fifo against a queue-based reference model.
module tb_fifo;

  localparam int unsigned WIDTH = 96;
  localparam int unsigned DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             wr = 1'b0;
  logic             rd = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             full, empty, half_full, almost_full, almost_empty;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [WIDTH-1:0] model_q [$];
  bit               model_valid = 1'b0;

  always #5 clk = ~clk;

  fifo #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_LEVEL  (DEPTH - 1),
    .AE_LEVEL  (1),
    .SIM_CHECKS(1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .wr          (wr),
    .rd          (rd),
    .dout        (dout),
    .full        (full),
    .empty       (empty),
    .half_full   (half_full),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO is a queue; a word enters only if there is room after the pop.
  always @(posedge clk) begin
    if (!reset) begin
      model_q.delete();
      model_valid = 1'b1;
    end else if (model_valid) begin
      bit do_pop, do_push;
      do_pop  = rd && (model_q.size() > 0);
      do_push = wr && ((model_q.size() < DEPTH) || rd);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      int n;
      n = model_q.size();
      chk("dout", dout, (n > 0) ? model_q[0] : '0);
      chk("empty", WIDTH'(empty), WIDTH'(n == 0));
      chk("full", WIDTH'(full), WIDTH'(n == DEPTH));
      chk("half_full", WIDTH'(half_full), WIDTH'(n >= DEPTH / 2));
      chk("almost_full", WIDTH'(almost_full), WIDTH'(n >= DEPTH - 1));
      chk("almost_empty", WIDTH'(almost_empty), WIDTH'(n <= 1));
    end
  end

  // Inputs change on the falling edge, so each call is exactly one rising edge.
  task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int wr_pct, rd_pct;
    @(negedge clk);

    // Reset held with wr asserted: nothing may be stored.
    cycle(1'b1, 1'b0, 96'h77);
    cycle(1'b1, 1'b0, 96'h78);
    chk("rst_empty", WIDTH'(empty), 96'd1);
    chk("rst_almost_empty", WIDTH'(almost_empty), 96'd1);
    chk("rst_full", WIDTH'(full), 96'd0);
    chk("rst_dout", dout, 96'd0);
    reset = 1'b1;
    cycle(1'b0, 1'b0, '0);
    chk("rst_nothing_stored", WIDTH'(empty), 96'd1);

    // FWFT: written word is on dout right after its write edge.
    cycle(1'b1, 1'b0, 96'hABC);
    chk("fwft_dout", dout, 96'hABC);
    chk("fwft_empty", WIDTH'(empty), 96'd0);
    cycle(1'b0, 1'b1, '0);
    chk("fwft_pop_empty", WIDTH'(empty), 96'd1);

    // Fill with 1..16, then one dropped write.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, WIDTH'(i));
      if (i == 7)  chk("hf_at_7", WIDTH'(half_full), 96'd0);
      if (i == 8)  chk("hf_at_8", WIDTH'(half_full), 96'd1);
      if (i == 14) chk("af_at_14", WIDTH'(almost_full), 96'd0);
      if (i == 15) chk("af_at_15", WIDTH'(almost_full), 96'd1);
      if (i == 15) chk("full_at_15", WIDTH'(full), 96'd0);
    end
    chk("full_at_16", WIDTH'(full), 96'd1);
    cycle(1'b1, 1'b0, 96'h11);
    chk("drop_full", WIDTH'(full), 96'd1);
    chk("drop_head", dout, 96'h1);

    // Drain in order; extra pops are ignored, even alongside a write.
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", dout, WIDTH'(i));
      cycle(1'b0, 1'b1, '0);
    end
    chk("drain_empty", WIDTH'(empty), 96'd1);
    cycle(1'b0, 1'b1, '0);
    chk("extra_rd_empty", WIDTH'(empty), 96'd1);
    cycle(1'b1, 1'b1, 96'h55);
    chk("rdwr_empty_dout", dout, 96'h55);
    chk("rdwr_empty_ae", WIDTH'(almost_empty), 96'd1);
    cycle(1'b0, 1'b1, '0);

    // Five resident words, then 40 concurrent wr+rd cycles.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, WIDTH'(100 + i));
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, WIDTH'(200 + i));
    chk("conc_head", dout, 96'd235);
    chk("conc_ae", WIDTH'(almost_empty), 96'd0);
    chk("conc_hf", WIDTH'(half_full), 96'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0);

    // Full FIFO with simultaneous wr+rd, then reset mid-stream.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, WIDTH'(32'h300 + i));
    cycle(1'b1, 1'b1, 96'h99);
    chk("fullrw_full", WIDTH'(full), 96'd1);
    chk("fullrw_head", dout, 96'h301);
    reset = 1'b0;
    cycle(1'b1, 1'b1, 96'h42);
    reset = 1'b1;
    chk("midrst_empty", WIDTH'(empty), 96'd1);
    chk("midrst_full", WIDTH'(full), 96'd0);
    chk("midrst_hf", WIDTH'(half_full), 96'd0);
    chk("midrst_af", WIDTH'(almost_full), 96'd0);
    chk("midrst_dout", dout, 96'd0);

    // Random traffic in phases of differing wr/rd pressure, with rare resets.
    for (int ph = 0; ph < 12; ph++) begin
      wr_pct = 20 + 30 * int'($urandom_range(0, 2));
      rd_pct = 20 + 30 * int'($urandom_range(0, 2));
      for (int c = 0; c < 250; c++) begin
        reset = ($urandom_range(0, 199) != 0);
        cycle(($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < rd_pct),
              {$urandom, $urandom, $urandom});
      end
    end
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
